// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package hex_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam int MAX_DIGITS = 32;

    // Anode pattern with every digit switched off, for either drive polarity.
    function automatic logic [MAX_DIGITS-1:0] an_inactive(input bit active_low);
        return active_low ? {MAX_DIGITS{1'b1}} : {MAX_DIGITS{1'b0}};
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hex_display.sv
// Hex nibble to 7-segment decoder; bit 6 = segment a, bit 0 = segment g, active-high.
module hex_display (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b0000000;
        case (hex_i)
            4'h0: seg_o = 7'b1111110;
            4'h1: seg_o = 7'b0110000;
            4'h2: seg_o = 7'b1101101;
            4'h3: seg_o = 7'b1111001;
            4'h4: seg_o = 7'b0110011;
            4'h5: seg_o = 7'b1011011;
            4'h6: seg_o = 7'b1011111;
            4'h7: seg_o = 7'b1110000;
            4'h8: seg_o = 7'b1111111;
            4'h9: seg_o = 7'b1111011;
            4'hA: seg_o = 7'b1110111;
            4'hB: seg_o = 7'b0011111;
            4'hC: seg_o = 7'b1001110;
            4'hD: seg_o = 7'b0111101;
            4'hE: seg_o = 7'b1001111;
            4'hF: seg_o = 7'b1000111;
            default: seg_o = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan controller: blank gap, leading-zero suppression and
// frame-atomic value updates over a valid/ready handshake.
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int NDIGITS       = 4,
    parameter int SHOW_CYCLES   = 50000,
    parameter int BLANK_CYCLES  = 500,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   lz_en,
    input  logic                   load_valid,
    input  logic [4*NDIGITS-1:0]   load_data,
    input  logic [NDIGITS-1:0]     load_dp,
    output logic                   load_ready,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame_done
);

    localparam int CNT_MAX = max_int(SHOW_CYCLES, BLANK_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NDIGITS - 1);
    localparam logic [MAX_DIGITS-1:0] AN_OFF_W   = an_inactive(AN_ACTIVE_LOW != 0);
    localparam logic [NDIGITS-1:0]    AN_OFF     = AN_OFF_W[NDIGITS-1:0];

    scan_state_t          state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [4*NDIGITS-1:0] disp_q, disp_d;
    logic [NDIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*NDIGITS-1:0] pend_q, pend_d;
    logic [NDIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                 pend_full_q, pend_full_d;

    logic [6:0]           seg_q;
    logic                 dp_q;
    logic [NDIGITS-1:0]   an_q;
    logic                 frame_done_q;

    logic [3:0]           nib_arr [NDIGITS];
    logic [NDIGITS-1:0]   lead_zero;
    logic [NDIGITS-1:0]   supp;
    logic [3:0]           nib_sel;
    logic [6:0]           dec_seg;
    logic [NDIGITS-1:0]   an_sel;
    logic                 show_end;
    logic                 frame_end;
    logic                 boundary;
    logic                 accept;

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
            assign nib_arr[gi] = disp_q[gi*4 +: 4];
            if (gi == 0) begin : g_lsd
                assign supp[gi] = 1'b0;
            end else begin : g_upper
                assign supp[gi] = lz_en && lead_zero[gi];
            end
        end
    endgenerate

    // lead_zero[i]: every nibble from the most significant down to i is zero.
    always_comb begin
        logic run;
        run = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            run          = run && (nib_arr[i] == 4'd0);
            lead_zero[i] = run;
        end
    end

    assign nib_sel = nib_arr[idx_q];
    assign an_sel  = AN_OFF ^ (NDIGITS'(1) << idx_q);

    hex_display u_dec (
        .hex_i (nib_sel),
        .seg_o (dec_seg)
    );

    assign show_end   = (state_q == ST_SHOW) && (cnt_q == SHOW_LAST);
    assign frame_end  = enable && show_end && (idx_q == IDX_LAST);
    assign boundary   = (state_q == ST_IDLE) || frame_end;
    assign load_ready = !pend_full_q && !rst;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;

            // Gating on enable blanks the digit on the same edge the scan stops.
            if (enable && (state_q == ST_SHOW)) begin
                an_q  <= an_sel;
                seg_q <= supp[idx_q] ? 7'b0000000 : dec_seg;
                dp_q  <= disp_dp_q[idx_q];
            end else begin
                an_q  <= AN_OFF;
                seg_q <= '0;
                dp_q  <= 1'b0;
            end

            if (!enable) begin
                state_q <= ST_IDLE;
                idx_q   <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_BLANK;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end
                    ST_BLANK: begin
                        if (cnt_q == BLANK_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_SHOW;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        if (cnt_q == SHOW_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_BLANK;
                            idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    // A load can only be taken while the slot is empty, so it never lands on
    // the boundary that drains the slot; it waits for the following one.
    always_comb begin
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        if (boundary && pend_full_q) begin
            disp_d      = pend_q;
            disp_dp_d   = pend_dp_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = load_data;
            pend_dp_d   = load_dp;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q      <= '0;
            disp_dp_q   <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
        end else begin
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with NDIGITS=4, SHOW=4, BLANK=2, active-low anodes.
module tb_hex_scan_ctrl;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] SA = 7'b1110111;
    localparam logic [6:0] SZ = 7'b0000000;

    // Per-frame expected segments, packed {digit3, digit2, digit1, digit0}.
    localparam logic [27:0] F_12A0    = {S1, S2, SA, S0};
    localparam logic [27:0] F_0005_LZ = {SZ, SZ, SZ, S5};
    localparam logic [27:0] F_0000_LZ = {SZ, SZ, SZ, S0};
    localparam logic [27:0] F_0000    = {S0, S0, S0, S0};
    localparam logic [27:0] F_1111    = {S1, S1, S1, S1};
    localparam logic [27:0] F_2222    = {S2, S2, S2, S2};

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        lz_en;
    logic        load_valid;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic        load_ready;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    hex_scan_ctrl #(
        .NDIGITS       (4),
        .SHOW_CYCLES   (4),
        .BLANK_CYCLES  (2),
        .AN_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .lz_en      (lz_en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_ready (load_ready),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, " an"}, {28'b0, an}, 32'hF);
        chk({tag, " seg"}, {25'b0, seg}, 32'h0);
        chk({tag, " dp"}, {31'b0, dp}, 32'h0);
    endtask

    // One clock of a 24-cycle frame: k%6 < 2 is the blank gap, else digit k/6.
    task automatic check_cycle(input int k, input logic [27:0] segs, input logic [3:0] dpm);
        int pos;
        int d;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        tick();
        pos = k % 6;
        d   = k / 6;
        if (pos >= 2) begin
            ea = 4'hF ^ (4'b0001 << d);
            es = segs[d*7 +: 7];
            ed = dpm[d];
        end else begin
            ea = 4'hF;
            es = 7'b0;
            ed = 1'b0;
        end
        chk($sformatf("an k=%0d", k), {28'b0, an}, {28'b0, ea});
        chk($sformatf("seg k=%0d", k), {25'b0, seg}, {25'b0, es});
        chk($sformatf("dp k=%0d", k), {31'b0, dp}, {31'b0, ed});
        chk($sformatf("frame_done k=%0d", k), {31'b0, frame_done}, {31'b0, (k == 23)});
    endtask

    task automatic run_frame(input logic [27:0] segs, input logic [3:0] dpm);
        for (int k = 0; k < 24; k++) check_cycle(k, segs, dpm);
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        lz_en      = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0;
        load_dp    = 4'h0;

        // Reset state
        tick();
        tick();
        chk_blank("reset");
        chk("reset frame_done", {31'b0, frame_done}, 32'h0);
        chk("reset load_ready", {31'b0, load_ready}, 32'h0);
        rst = 1'b0;
        #1;
        chk("post-reset load_ready", {31'b0, load_ready}, 32'h1);

        // Load 0x12A0 while idle, then scan without suppression
        load_valid = 1'b1;
        load_data  = 16'h12A0;
        load_dp    = 4'b0000;
        tick();
        load_valid = 1'b0;
        chk("idle load_ready busy", {31'b0, load_ready}, 32'h0);
        tick();
        chk("idle boundary load_ready", {31'b0, load_ready}, 32'h1);
        enable = 1'b1;
        tick();
        chk_blank("enable edge");
        run_frame(F_12A0, 4'b0000);

        // Leading-zero suppression with 0x0005
        lz_en      = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h0005;
        for (int k = 0; k < 24; k++) begin
            check_cycle(k, F_12A0, 4'b0000);
            if (k == 0) begin
                load_valid = 1'b0;
                chk("lz load_ready busy", {31'b0, load_ready}, 32'h0);
            end
        end
        for (int k = 0; k < 24; k++) begin
            check_cycle(k, F_0005_LZ, 4'b0000);
            if (k == 0) chk("lz load_ready free", {31'b0, load_ready}, 32'h1);
        end

        // Leading-zero suppression with 0x0000
        load_valid = 1'b1;
        load_data  = 16'h0000;
        for (int k = 0; k < 24; k++) begin
            check_cycle(k, F_0005_LZ, 4'b0000);
            if (k == 0) load_valid = 1'b0;
        end
        run_frame(F_0000_LZ, 4'b0000);

        // Held valid mid-frame: 0x1111 then 0x2222
        lz_en = 1'b0;
        for (int k = 0; k < 24; k++) begin
            check_cycle(k, F_0000, 4'b0000);
            if (k == 9) begin
                load_valid = 1'b1;
                load_data  = 16'h1111;
            end
            if (k == 10) begin
                chk("hold 1111 accepted", {31'b0, load_ready}, 32'h0);
                load_data = 16'h2222;
            end
            if (k == 23) chk("hold boundary ready", {31'b0, load_ready}, 32'h1);
        end
        for (int k = 0; k < 24; k++) begin
            check_cycle(k, F_1111, 4'b0000);
            if (k == 0) begin
                chk("hold 2222 accepted", {31'b0, load_ready}, 32'h0);
                load_valid = 1'b0;
            end
        end

        // Decimal point on digit 2
        load_valid = 1'b1;
        load_data  = 16'h2222;
        load_dp    = 4'b0100;
        for (int k = 0; k < 24; k++) begin
            check_cycle(k, F_2222, 4'b0000);
            if (k == 0) load_valid = 1'b0;
        end
        run_frame(F_2222, 4'b0100);

        // Disable during digit 2 SHOW, then re-enable
        for (int k = 0; k < 15; k++) check_cycle(k, F_2222, 4'b0100);
        enable = 1'b0;
        tick();
        chk_blank("disable");
        tick();
        chk_blank("idle");
        enable = 1'b1;
        tick();
        chk_blank("re-enable edge");

        // Reset mid-frame with a pending value
        for (int k = 0; k < 9; k++) begin
            check_cycle(k, F_2222, 4'b0100);
            if (k == 5) begin
                load_valid = 1'b1;
                load_data  = 16'h8888;
                load_dp    = 4'b1111;
            end
            if (k == 6) begin
                load_valid = 1'b0;
                chk("pending before rst", {31'b0, load_ready}, 32'h0);
            end
        end
        rst = 1'b1;
        #1;
        chk("rst load_ready", {31'b0, load_ready}, 32'h0);
        tick();
        chk_blank("mid-frame rst");
        chk("mid-frame rst frame_done", {31'b0, frame_done}, 32'h0);
        chk("mid-frame rst load_ready", {31'b0, load_ready}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("release load_ready", {31'b0, load_ready}, 32'h1);
        tick();
        chk_blank("restart edge");
        run_frame(F_0000, 4'b0000);
        run_frame(F_0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
